// File: rtl/byte_mem_ctrl.sv
// byte_mem_ctrl -- single-port byte-addressed memory behind a request/response
// handshake. One request is in flight at a time.
//
// Handshake rule (both channels): a transfer happens at a rising clk edge
// where valid && ready are both 1. Once resp_valid rises, resp_valid,
// resp_rdata and resp_err hold until the edge where resp_ready is 1.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid / req_ready   request handshake (req_ready = 1 only when idle)
//   req_wr                  1 = write, 0 = read
//   req_addr                byte address (little-endian word layout)
//   req_wdata, req_be       write data and per-byte write enables
//   resp_valid / resp_ready response handshake
//   resp_rdata              read data (0 for writes and rejected requests)
//   resp_err                request was rejected (out of range / misaligned)
//   dbg_state               FSM state: 0 = IDLE, 1 = WAIT, 2 = RESP
module byte_mem_ctrl #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_BYTES = 1024,
  parameter int READ_LAT    = 1,
  parameter int MISALIGN_OK = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic [1:0]          dbg_state
);

  localparam int NB     = DATA_W / 8;
  localparam int AW     = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  // WAIT lasts READ_LAT-1 cycles; the counter is loaded with one less than that
  // so that it exits when it reads zero.
  localparam int LAT_M2 = (READ_LAT > 1) ? READ_LAT - 2 : 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [7:0]        mem [DEPTH_BYTES];
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              accept;
  logic              oob;
  logic              misalign;
  logic              addr_err;
  logic              do_write;
  logic [32:0]       last_byte;
  logic [AW-1:0]     base;

  // Bounds check is done in 33 bits so addresses near 2^32 cannot wrap
  // around and look in range.
  assign last_byte = {1'b0, req_addr} + 33'(NB - 1);
  assign oob       = (last_byte >= 33'(DEPTH_BYTES));
  assign misalign  = (MISALIGN_OK == 0) && ((req_addr % 32'(NB)) != 32'd0);
  assign addr_err  = oob || misalign;

  assign req_ready  = (state_q == IDLE);
  assign accept     = req_valid && req_ready;
  assign do_write   = accept && req_wr && !addr_err;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign dbg_state  = state_q;

  // Low address bits select the first byte; upper bits only matter for the
  // bounds check, and an out-of-range word is discarded anyway.
  assign base = req_addr[AW-1:0];

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NB; k++) begin
      rd_word[8*k +: 8] = mem[base + AW'(k)];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_wr || READ_LAT == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 3'(LAT_M2);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Response data is captured at the accept edge. Memory shares this block so
  // that an accept edge seen while rst_n is low never writes; the array itself
  // is deliberately not reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        err_q   <= addr_err;
        rdata_q <= (req_wr || addr_err) ? '0 : rd_word;
      end
      if (do_write) begin
        for (int k = 0; k < NB; k++) begin
          if (req_be[k]) begin
            mem[base + AW'(k)] <= req_wdata[8*k +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_byte_mem_ctrl.sv
// Testbench for byte_mem_ctrl. Two instances share clock and reset:
//   dut 0: DATA_W=32, DEPTH_BYTES=1024, READ_LAT=1, MISALIGN_OK=0
//   dut 1: DATA_W=32, DEPTH_BYTES=1024, READ_LAT=3, MISALIGN_OK=1
// Inputs are driven and outputs sampled on the falling edge.
module tb_byte_mem_ctrl;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_wr     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [3:0]  req_be     [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];
  logic [1:0]  dbg_state  [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference byte memory per instance.
  logic [7:0] mdl [2][DEPTH];

  always #5 clk = ~clk;

  byte_mem_ctrl #(.DATA_W(32), .DEPTH_BYTES(1024), .READ_LAT(1), .MISALIGN_OK(0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wr(req_wr[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .dbg_state(dbg_state[0])
  );

  byte_mem_ctrl #(.DATA_W(32), .DEPTH_BYTES(1024), .READ_LAT(3), .MISALIGN_OK(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wr(req_wr[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .dbg_state(dbg_state[1])
  );

  // ---------------- reference model ----------------
  // Rejected if any byte of the word lies past the end, or (dut 0 only) if the
  // address is not a multiple of 4. Accepted writes update enabled bytes.
  task automatic model_access(input int d, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              output logic [31:0] er, output logic ee);
    logic [63:0] last;
    last = {32'd0, addr} + 64'd3;
    ee = (last >= 64'(DEPTH)) || (d == 0 && (addr % 4) != 0);
    er = '0;
    if (!ee) begin
      for (int k = 0; k < 4; k++) begin
        if (wr) begin
          if (be[k]) mdl[d][int'(addr) + k] = wdata[8*k +: 8];
        end else begin
          er[8*k +: 8] = mdl[d][int'(addr) + k];
        end
      end
    end
  endtask

  function automatic int exp_lat(input int d, input logic wr);
    return (wr || d == 0) ? 1 : 3;
  endfunction

  // ---------------- driver ----------------
  // Starts at a falling edge with the instance idle; returns at the falling
  // edge after the response handshake. lat = cycles from accept edge to the
  // first edge at which resp_valid is high.
  task automatic issue(input int d, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int hold,
                       output logic [31:0] rdata, output logic err, output int lat);
    req_valid[d] = 1'b1;
    req_wr[d]    = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_be[d]    = be;
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    lat = 1;
    while (!resp_valid[d] && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    rdata = resp_rdata[d];
    err   = resp_err[d];
    repeat (hold) @(negedge clk);
    resp_ready[d] = 1'b1;
    @(negedge clk);
    resp_ready[d] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0 || resp_rdata[d] !== 32'd0 ||
          resp_err[d] !== 1'b0 || dbg_state[d] !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: ready=%b valid=%b rdata=%h err=%b state=%0d, want 1 0 0 0 0",
                 d, req_ready[d], resp_valid[d], resp_rdata[d], resp_err[d], dbg_state[d]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill;
    logic [31:0] wd, rd, er;
    logic re, ee;
    int lat;
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < DEPTH; a += 4) begin
        wd = $urandom;
        model_access(d, 1'b1, 32'(a), wd, 4'hF, er, ee);
        issue(d, 1'b1, 32'(a), wd, 4'hF, 0, rd, re, lat);
        n_checks++;
        if (re !== ee || rd !== 32'd0 || lat != 1) begin
          n_fail++;
          $display("FAIL fill_write dut%0d addr %0d: err=%b rdata=%h lat=%0d, want err=%b rdata=0 lat=1",
                   d, a, re, rd, lat, ee);
        end
      end
    end
  endtask

  task automatic test_write_read;
    logic [31:0] rd, er;
    logic re, ee;
    int lat;
    model_access(0, 1'b1, 32'd8, 32'hDEADBEEF, 4'hF, er, ee);
    issue(0, 1'b1, 32'd8, 32'hDEADBEEF, 4'hF, 0, rd, re, lat);
    n_checks++;
    if (re !== 1'b0 || rd !== 32'd0) begin
      n_fail++;
      $display("FAIL wr_resp: err=%b rdata=%h, want err=0 rdata=0", re, rd);
    end
    issue(0, 1'b0, 32'd8, 32'd0, 4'h0, 0, rd, re, lat);
    n_checks++;
    if (rd !== 32'hDEADBEEF || re !== 1'b0 || lat != 1) begin
      n_fail++;
      $display("FAIL rd_addr8: rdata=%h err=%b lat=%0d, want DEADBEEF 0 1", rd, re, lat);
    end
    issue(0, 1'b0, 32'd9, 32'd0, 4'h0, 0, rd, re, lat);
    n_checks++;
    if (re !== 1'b1 || rd !== 32'd0) begin
      n_fail++;
      $display("FAIL rd_misaligned: err=%b rdata=%h, want err=1 rdata=0", re, rd);
    end
  endtask

  task automatic test_byte_enable;
    logic [31:0] rd, er;
    logic re, ee;
    int lat;
    model_access(0, 1'b1, 32'd8, 32'h11223344, 4'h5, er, ee);
    issue(0, 1'b1, 32'd8, 32'h11223344, 4'h5, 0, rd, re, lat);
    issue(0, 1'b0, 32'd8, 32'd0, 4'h0, 0, rd, re, lat);
    n_checks++;
    if (rd !== 32'hDE22BE44 || re !== 1'b0) begin
      n_fail++;
      $display("FAIL byte_enable: rdata=%h err=%b, want DE22BE44 0", rd, re);
    end
    // All enables clear: no change, still a clean response.
    model_access(0, 1'b1, 32'd40, 32'hA5A5A5A5, 4'h0, er, ee);
    issue(0, 1'b1, 32'd40, 32'hA5A5A5A5, 4'h0, 0, rd, re, lat);
    n_checks++;
    if (re !== 1'b0) begin
      n_fail++;
      $display("FAIL be_zero_resp: err=%b, want 0", re);
    end
    model_access(0, 1'b0, 32'd40, 32'd0, 4'h0, er, ee);
    issue(0, 1'b0, 32'd40, 32'd0, 4'h0, 0, rd, re, lat);
    n_checks++;
    if (rd !== er || re !== 1'b0) begin
      n_fail++;
      $display("FAIL be_zero_data: rdata=%h err=%b, want %h 0", rd, re, er);
    end
  endtask

  task automatic test_bounds;
    logic [31:0] rd, er;
    logic re, ee;
    int lat;
    // dut 0: last full word, then first word past the end.
    model_access(0, 1'b0, 32'd1020, 32'd0, 4'h0, er, ee);
    issue(0, 1'b0, 32'd1020, 32'd0, 4'h0, 0, rd, re, lat);
    n_checks++;
    if (re !== 1'b0 || rd !== er) begin
      n_fail++;
      $display("FAIL rd_1020: err=%b rdata=%h, want 0 %h", re, rd, er);
    end
    issue(0, 1'b0, 32'd1024, 32'd0, 4'h0, 0, rd, re, lat);
    n_checks++;
    if (re !== 1'b1 || rd !== 32'd0 || lat != 1) begin
      n_fail++;
      $display("FAIL rd_1024: err=%b rdata=%h lat=%0d, want 1 0 1", re, rd, lat);
    end
    // dut 1 (misaligned allowed): straddling write is rejected, memory intact.
    issue(1, 1'b1, 32'd1022, 32'h0BADF00D, 4'hF, 0, rd, re, lat);
    n_checks++;
    if (re !== 1'b1 || rd !== 32'd0) begin
      n_fail++;
      $display("FAIL wr_1022: err=%b rdata=%h, want 1 0", re, rd);
    end
    model_access(1, 1'b0, 32'd1019, 32'd0, 4'h0, er, ee);
    issue(1, 1'b0, 32'd1019, 32'd0, 4'h0, 0, rd, re, lat);
    n_checks++;
    if (re !== 1'b0 || rd !== er || lat != 3) begin
      n_fail++;
      $display("FAIL rd_1019_after_1022: err=%b rdata=%h lat=%0d, want 0 %h 3", re, rd, lat, er);
    end
    issue(1, 1'b0, 32'd1021, 32'd0, 4'h0, 0, rd, re, lat);
    n_checks++;
    if (re !== 1'b1 || rd !== 32'd0 || lat != 3) begin
      n_fail++;
      $display("FAIL rd_1021: err=%b rdata=%h lat=%0d, want 1 0 3", re, rd, lat);
    end
    issue(1, 1'b0, 32'hFFFF_FFFE, 32'd0, 4'h0, 0, rd, re, lat);
    n_checks++;
    if (re !== 1'b1 || rd !== 32'd0) begin
      n_fail++;
      $display("FAIL rd_nowrap: err=%b rdata=%h, want 1 0", re, rd);
    end
  endtask

  task automatic test_latency;
    logic [31:0] rd, er, a;
    logic re, ee;
    int lat;
    for (int d = 0; d < 2; d++) begin
      a = 32'($urandom_range(0, 255) * 4);
      model_access(d, 1'b0, a, 32'd0, 4'h0, er, ee);
      issue(d, 1'b0, a, 32'd0, 4'h0, 0, rd, re, lat);
      n_checks++;
      if (lat != exp_lat(d, 1'b0) || rd !== er || re !== 1'b0) begin
        n_fail++;
        $display("FAIL read_latency dut%0d: lat=%0d rdata=%h err=%b, want %0d %h 0",
                 d, lat, rd, re, exp_lat(d, 1'b0), er);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] er, cap_d, rd, a;
    logic ee, cap_e, re;
    int lat;
    a = 32'd200;
    model_access(0, 1'b0, a, 32'd0, 4'h0, er, ee);
    req_valid[0] = 1'b1; req_wr[0] = 1'b0; req_addr[0] = a;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    lat = 1;
    while (!resp_valid[0] && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    cap_d = resp_rdata[0];
    cap_e = resp_err[0];
    n_checks++;
    if (resp_valid[0] !== 1'b1 || cap_d !== er || cap_e !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_first: valid=%b rdata=%h err=%b, want 1 %h 0", resp_valid[0], cap_d, cap_e, er);
    end
    // Offer a write while busy; it must be ignored.
    req_valid[0] = 1'b1; req_wr[0] = 1'b1; req_wdata[0] = ~er; req_be[0] = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== cap_d || resp_err[0] !== cap_e ||
          req_ready[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: valid=%b rdata=%h err=%b ready=%b, want 1 %h %b 0",
                 i, resp_valid[0], resp_rdata[0], resp_err[0], req_ready[0], cap_d, cap_e);
      end
    end
    resp_ready[0] = 1'b1;
    @(negedge clk);
    resp_ready[0] = 1'b0;
    req_valid[0]  = 1'b0;
    n_checks++;
    if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: ready=%b valid=%b, want 1 0", req_ready[0], resp_valid[0]);
    end
    issue(0, 1'b0, a, 32'd0, 4'h0, 0, rd, re, lat);
    n_checks++;
    if (rd !== er || re !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_ignored_write: rdata=%h err=%b, want %h 0", rd, re, er);
    end
  endtask

  task automatic test_random;
    logic [31:0] exp_q[$];
    logic [31:0] a, wd, rd, er, exp_d;
    logic [3:0] be;
    logic wr, re, ee;
    int d, lat, r;
    for (int n = 0; n < 300; n++) begin
      d  = $urandom_range(0, 1);
      wr = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 9);
      if (r < 6)      a = 32'($urandom_range(0, 255) * 4);
      else if (r < 9) a = 32'($urandom_range(0, 1030));
      else            a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      wd = $urandom;
      be = 4'($urandom_range(0, 15));
      model_access(d, wr, a, wd, be, er, ee);
      exp_q.push_back(er);
      issue(d, wr, a, wd, be, $urandom_range(0, 3), rd, re, lat);
      exp_d = exp_q.pop_front();
      n_checks++;
      if (rd !== exp_d || re !== ee || lat != exp_lat(d, wr)) begin
        n_fail++;
        $display("FAIL random #%0d dut%0d wr=%b addr=%h: rdata=%h err=%b lat=%0d, want %h %b %0d",
                 n, d, wr, a, rd, re, lat, exp_d, ee, exp_lat(d, wr));
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd, er, old;
    logic re, ee, seen;
    int lat;
    // Reset while dut 1 waits on a read.
    req_valid[1] = 1'b1; req_wr[1] = 1'b0; req_addr[1] = 32'd64;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (resp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1 || resp_rdata[1] !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b ready=%b rdata=%h, want 0 1 0",
               resp_valid[1], req_ready[1], resp_rdata[1]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen = seen | resp_valid[1];
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_resp: resp_valid seen=%b, want 0", seen);
    end
    model_access(1, 1'b0, 32'd64, 32'd0, 4'h0, er, ee);
    issue(1, 1'b0, 32'd64, 32'd0, 4'h0, 0, rd, re, lat);
    n_checks++;
    if (rd !== er || re !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_keeps_mem: rdata=%h err=%b, want %h 0", rd, re, er);
    end
    // Write whose accept edge falls inside reset must not land.
    model_access(0, 1'b0, 32'd16, 32'd0, 4'h0, old, ee);
    req_valid[0] = 1'b1; req_wr[0] = 1'b1; req_addr[0] = 32'd16;
    req_wdata[0] = ~old; req_be[0] = 4'hF;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    issue(0, 1'b0, 32'd16, 32'd0, 4'h0, 0, rd, re, lat);
    n_checks++;
    if (rd !== old || re !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_write_blocked: rdata=%h err=%b, want %h 0", rd, re, old);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_wr[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0; req_be[d] = '0; resp_ready[d] = 1'b0;
    end
    @(negedge clk);
    test_reset;
    test_fill;
    test_write_read;
    test_byte_enable;
    test_bounds;
    test_latency;
    test_backpressure;
    test_random;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
